// File: rtl/led_pkg.sv
// Shared types and constants for the LED stretcher: channel FSM states and the PWM helpers.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    HOLD = 2'd2
  } chan_state_e;

  localparam logic [3:0] PWM_MAX     = 4'd14;
  localparam logic [3:0] BRIGHT_FULL = 4'd15;

  // Full brightness bypasses the counter so that level 15 is a true 100% duty.
  function automatic logic pwm_gate(input logic [3:0] cnt, input logic [3:0] bright);
    return (bright == BRIGHT_FULL) || (cnt < bright);
  endfunction

endpackage

// File: rtl/led_stretch_if.sv
// LED drive bundle: activity inputs and brightness toward the stretcher, LED drive back.
interface led_stretch_if #(
  parameter int NUM_LEDS = 8
);
  logic [NUM_LEDS-1:0] led_in;
  logic [3:0]          brightness;
  logic [NUM_LEDS-1:0] led_out;

  modport master (output led_in, output brightness, input led_out);
  modport slave  (input led_in, input brightness, output led_out);
endinterface

// File: rtl/led_stretch_chan.sv
// One LED channel: IDLE/ON/HOLD FSM with a hold counter decremented on prescaler ticks.
module led_stretch_chan
  import led_pkg::*;
#(
  parameter int HOLD_TICKS = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_led,
  output logic o_lit_next
);

  localparam int CNT_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  chan_state_e      r_state;
  chan_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A high input in HOLD retriggers before any tick is considered.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_led) begin
          w_state_next = ON;
        end else begin
          w_state_next = IDLE;
        end
      end
      ON: begin
        if (i_led) begin
          w_state_next = ON;
        end else if (HOLD_TICKS == 0) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = HOLD;
          w_cnt_next   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (i_led) begin
          w_state_next = ON;
        end else if (i_tick) begin
          if (r_cnt <= CNT_ONE) begin
            w_state_next = IDLE;
            w_cnt_next   = CNT_ZERO;
          end else begin
            w_state_next = HOLD;
            w_cnt_next   = r_cnt - CNT_ONE;
          end
        end else begin
          w_state_next = HOLD;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  assign o_lit_next = (w_state_next != IDLE);

endmodule

// File: rtl/led_stretch.sv
// LED pulse stretcher: per-channel stretch FSMs, shared hold-tick prescaler and PWM dimming.
module led_stretch
  import led_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PRESCALE   = 160000,
  parameter int HOLD_TICKS = 50
) (
  input  logic                clock_160,
  input  logic                res,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [3:0]          brightness,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int PRE_W = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0]    r_presc;
  logic                w_tick;
  logic [3:0]          r_pwm_cnt;
  logic                w_gate;
  logic [NUM_LEDS-1:0] w_lit_next;
  logic [NUM_LEDS-1:0] r_led_out;

  assign w_tick = (r_presc == PRE_LAST);

  always_ff @(posedge clock_160) begin
    if (res) begin
      r_presc <= PRE_ZERO;
    end else if (w_tick) begin
      r_presc <= PRE_ZERO;
    end else begin
      r_presc <= r_presc + PRE_ONE;
    end
  end

  always_ff @(posedge clock_160) begin
    if (res) begin
      r_pwm_cnt <= 4'd0;
    end else if (r_pwm_cnt == PWM_MAX) begin
      r_pwm_cnt <= 4'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    led_stretch_chan #(
      .HOLD_TICKS (HOLD_TICKS)
    ) u_chan (
      .i_clk      (clock_160),
      .i_rst      (res),
      .i_tick     (w_tick),
      .i_led      (led_in[g]),
      .o_lit_next (w_lit_next[g])
    );
  end

  assign w_gate = pwm_gate(r_pwm_cnt, brightness);

  // Gating the next lit state gives one cycle from input edge to output edge.
  always_ff @(posedge clock_160) begin
    if (res) begin
      r_led_out <= {NUM_LEDS{1'b0}};
    end else begin
      r_led_out <= w_lit_next & {NUM_LEDS{w_gate}};
    end
  end

  assign led_out = r_led_out;

endmodule

// File: tb/tb_led_stretch.sv
// Directed bench for led_stretch: vector table plus multi-cycle hold, retrigger, PWM and reset sequences.
module tb_led_stretch;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] led_out0;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  led_stretch_if #(.NUM_LEDS(8)) bus ();

  led_stretch #(.NUM_LEDS(8), .PRESCALE(4), .HOLD_TICKS(3)) dut (
    .clock_160  (clk),
    .res        (res),
    .led_in     (bus.led_in),
    .brightness (bus.brightness),
    .led_out    (bus.led_out)
  );

  led_stretch #(.NUM_LEDS(8), .PRESCALE(4), .HOLD_TICKS(0)) dut0 (
    .clock_160  (clk),
    .res        (res),
    .led_in     (bus.led_in),
    .brightness (bus.brightness),
    .led_out    (led_out0)
  );

  typedef struct {
    logic       res;
    logic [7:0] li;
    logic [3:0] br;
    logic [7:0] exp;
    logic [7:0] exp0;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    res            = 1'b1;
    bus.led_in     = 8'h00;
    bus.brightness = 4'd15;
    step();
    res = 1'b0;
  endtask

  initial begin
    logic [7:0] others;
    logic       cont;
    int         n;
    int         n_on;
    int         n_off;
    logic       done;

    res            = 1'b1;
    bus.led_in     = 8'h00;
    bus.brightness = 4'd15;
    step();
    step();

    tbl[0]  = '{1'b1, 8'h00, 4'd15, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'h01, 4'd15, 8'h01, 8'h01};
    tbl[2]  = '{1'b0, 8'h00, 4'd15, 8'h01, 8'h00};
    tbl[3]  = '{1'b0, 8'h20, 4'd15, 8'h21, 8'h20};
    tbl[4]  = '{1'b0, 8'h00, 4'd15, 8'h21, 8'h00};
    tbl[5]  = '{1'b0, 8'h20, 4'd15, 8'h21, 8'h20};
    tbl[6]  = '{1'b0, 8'h00, 4'd0,  8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 4'd15, 8'h21, 8'h00};
    tbl[8]  = '{1'b0, 8'hA5, 4'd15, 8'hA5, 8'hA5};
    tbl[9]  = '{1'b0, 8'h5A, 4'd15, 8'hFF, 8'h5A};
    tbl[10] = '{1'b0, 8'h00, 4'd15, 8'hFF, 8'h00};
    tbl[11] = '{1'b1, 8'h00, 4'd15, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 8'h08, 4'd15, 8'h08, 8'h08};
    tbl[13] = '{1'b0, 8'h00, 4'd15, 8'h08, 8'h00};

    for (int i = 0; i < 14; i++) begin
      res            = tbl[i].res;
      bus.led_in     = tbl[i].li;
      bus.brightness = tbl[i].br;
      step();
      check($sformatf("vec%0d_hold3", i), bus.led_out, tbl[i].exp);
      check($sformatf("vec%0d_hold0", i), led_out0, tbl[i].exp0);
    end

    // Hold bounds after a long high period on channel 0.
    do_reset();
    others     = 8'h00;
    bus.led_in = 8'h01;
    for (int i = 0; i < 10; i++) begin
      step();
      others |= bus.led_out & 8'hFE;
    end
    check("long_high_on", bus.led_out, 8'h01);
    bus.led_in = 8'h00;
    step();
    check("hold_at_fall", bus.led_out, 8'h01);
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      step();
      n++;
      others |= bus.led_out & 8'hFE;
      if (bus.led_out[0] == 1'b0) done = 1'b1;
    end
    check_range("hold_fall_delay", n, 9, 12);
    check("hold_other_bits", others, 8'h00);

    // Retrigger on channel 2: two single-cycle pulses six cycles apart.
    do_reset();
    cont       = 1'b1;
    bus.led_in = 8'h04;
    step();
    cont &= bus.led_out[2];
    bus.led_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      cont &= bus.led_out[2];
    end
    bus.led_in = 8'h04;
    step();
    cont &= bus.led_out[2];
    bus.led_in = 8'h00;
    step();
    cont &= bus.led_out[2];
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      step();
      n++;
      if (bus.led_out[2] == 1'b0) done = 1'b1;
      else cont &= bus.led_out[2];
    end
    check("retrig_continuous", cont, 1);
    check_range("retrig_fall_delay", n, 9, 12);

    // Zero hold: output follows input one cycle later.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.led_in = (i % 2 == 0) ? 8'h20 : 8'h00;
      step();
      check($sformatf("zero_hold_%0d", i), led_out0, bus.led_in);
    end

    // PWM duty at brightness 5, then brightness 0 with FSM still running.
    do_reset();
    bus.brightness = 4'd5;
    bus.led_in     = 8'hFF;
    for (int i = 0; i < 3; i++) step();
    n_on  = 0;
    n_off = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.led_out == 8'hFF) n_on++;
      else if (bus.led_out == 8'h00) n_off++;
    end
    check("pwm5_on_cycles", n_on, 5);
    check("pwm5_off_cycles", n_off, 10);
    bus.brightness = 4'd0;
    others         = 8'h00;
    for (int i = 0; i < 16; i++) begin
      step();
      others |= bus.led_out;
    end
    check("bright0_dark", others, 8'h00);
    bus.led_in     = 8'h00;
    bus.brightness = 4'd15;
    step();
    check("bright0_state_kept", bus.led_out, 8'hFF);

    // Reset in the middle of a HOLD on channel 3.
    do_reset();
    bus.led_in = 8'h08;
    step();
    bus.led_in = 8'h00;
    step();
    step();
    check("pre_reset_hold", bus.led_out, 8'h08);
    res = 1'b1;
    step();
    check("reset_mid_hold", bus.led_out, 8'h00);
    res    = 1'b0;
    others = 8'h00;
    for (int i = 0; i < 15; i++) begin
      step();
      others |= bus.led_out;
    end
    check("after_reset_dark", others, 8'h00);

    // Channel 1 falls into HOLD in the same cycle channel 6 rises.
    do_reset();
    bus.led_in = 8'h02;
    step();
    step();
    check("ch1_on", bus.led_out, 8'h02);
    bus.led_in = 8'h40;
    step();
    check("simul_edge", bus.led_out, 8'h42);
    step();
    check("simul_next", bus.led_out, 8'h42);
    bus.led_in = 8'h00;
    step();
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      step();
      n++;
      if (bus.led_out == 8'h00) done = 1'b1;
    end
    check_range("simul_all_off", n, 9, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
